gate_exerciser: RTL and testbench
=================================

// Module: gate_exerciser
// PURPOSE
//   Driving/checking end of a 2-input gate interface: generates the a,b operands for a
//   combinational gate under test, samples the gate's out, and compares it with a truth table.
//   On start, steps {a,b} through 00,01,10,11, holds each vector HOLD_CYCLES clocks,
//   checks out on the last hold cycle, then reports pass/fail.
//   Used as on-board self-test wrapper around gate modules (andGate default truth table).
// PARAMETERS
//   HOLD_CYCLES  2        clocks each vector is held before out is sampled; legal range 1..255
//   EXPECT       4'b1000  expected out per vector, bit index = {a,b}; default = AND
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   rst         in   1  synchronous reset, active-high
//   start       in   1  begin a test run; sampled only in IDLE
//   gate_out    in   1  out of gate under test (combinational from a,b)
//   a           out  1  operand a to gate under test
//   b           out  1  operand b to gate under test
//   busy        out  1  high while a run is in progress
//   done        out  1  one-cycle pulse when a run completes
//   pass        out  1  result of last completed run (1 = all 4 vectors matched)
//   fail_vec    out  4  per-vector mismatch flags of last/current run, bit index = {a,b}
//   fail_count  out  3  number of mismatched vectors, 0..4
// BEHAVIOUR
//   Reset (rst=1 at clock edge): state=IDLE, a=b=0, busy=0, done=0, pass=0, fail_vec=0,
//     fail_count=0, vector index=0, hold counter=0. Reset mid-run aborts the run; no done pulse.
//   All outputs are registered; none depends combinationally on an input.
//   States:
//     IDLE : a=b=0, busy=0. start=1 -> DRIVE; on that edge index=0, hold counter=0,
//            fail_vec=0, fail_count=0, pass=0, busy=1, {a,b}=00.
//     DRIVE: {a,b}=index. Hold counter increments every cycle. In the cycle where counter ==
//            HOLD_CYCLES-1, gate_out is sampled at that edge:
//            if gate_out != EXPECT[index] -> fail_vec[index]<=1, fail_count<=fail_count+1.
//            On the same edge: index<3 -> index+1, counter<=0, stay DRIVE;
//            index==3 -> FINISH.
//     FINISH: single cycle. busy=0, done=1, pass=(fail_vec==0), a=b=0 -> IDLE.
//   done is high exactly one cycle, in FINISH. pass and fail_vec/fail_count then hold until the next
//     accepted start or reset.
//   Timing: start sampled at edge T -> busy=1 and {a,b}=00 from T+1. Vector k is driven cycles
//     T+1+k*HOLD_CYCLES .. T+(k+1)*HOLD_CYCLES. done=1 in cycle T+1+4*HOLD_CYCLES.
//     busy stays high for exactly 4*HOLD_CYCLES cycles.
//   start while busy or in FINISH: ignored, no restart, no error.
//   start held high continuously: a new run starts on the edge after FINISH (IDLE lasts 1 cycle).
//   HOLD_CYCLES=1: each vector lasts 1 cycle and is sampled in that same cycle.
//     The gate under test must settle within one clock.
//   Counter width: clog2(HOLD_CYCLES) bits, minimum 1. fail_count saturates naturally at 4 (no wrap).
//   gate_out is used only on sample edges; values between samples are don't-care.
// TESTING
//   1 Reset then start=1 for one cycle, gate_out=a&b, HOLD_CYCLES=2 -> a,b = 00,01,10,11
//     each for 2 cycles; done pulse at T+9; pass=1, fail_vec=0000, fail_count=0.
//   2 gate_out tied 0 -> fail_vec=1000, fail_count=1, pass=0.
//     gate_out tied 1 -> fail_vec=0111, fail_count=3.
//   3 gate_out=a|b with EXPECT=4'b1000 -> fail_vec=0110, fail_count=2, pass=0.
//     Same stimulus with EXPECT=4'b1110 -> pass=1.
//   4 Pulse start repeatedly during a run -> exactly one done, schedule unchanged.
//     start held high -> back-to-back runs, done every 4*HOLD_CYCLES+2 cycles.
//   5 Assert rst during the vector-10 hold -> next cycle all outputs are reset values, no done.
//     A following start runs a full clean sequence.
//   6 HOLD_CYCLES=1 and HOLD_CYCLES=5 -> busy width 4 and 20 cycles.
//     Sample taken on last hold cycle: inject a glitch on gate_out before it -> no failure.

Source files
------------

// File: rtl/gate_exerciser.sv
// Self-test driver for a 2-input combinational gate: walks {a,b} through 00..11,
// samples gate_out on the last hold cycle of each vector and checks it against EXPECT.
module gate_exerciser #(
  parameter int         HOLD_CYCLES = 2,
  parameter logic [3:0] EXPECT      = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] fail_count
);

  localparam int            CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [3:0]    fail_vec_q, fail_vec_d;
  logic [2:0]    fail_count_q, fail_count_d;

  // Next-state and next-output computation for the vector sequencer
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_vec_d   = fail_vec_q;
    fail_count_d = fail_count_q;
    case (state_q)
      S_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        if (start) begin
          state_d      = S_DRIVE;
          idx_d        = 2'd0;
          cnt_d        = '0;
          fail_vec_d   = 4'b0000;
          fail_count_d = 3'd0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          if (gate_out != EXPECT[idx_q]) begin
            fail_vec_d[idx_q] = 1'b1;
            fail_count_d      = fail_count_q + 3'd1;
          end else begin
            fail_count_d = fail_count_q;
          end
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            // Verdict includes the vector sampled on this very edge
            state_d = S_FINISH;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (fail_vec_d == 4'b0000);
          end else begin
            idx_d      = idx_q + 2'd1;
            {a_d, b_d} = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_vec_q   <= 4'b0000;
      fail_count_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_vec_q   <= fail_vec_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_vec   = fail_vec_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: four instances with different hold lengths and truth tables,
// a cycle-position reference model, per-cycle comparison and a few pinned literal results.
module tb_gate_exerciser;

  localparam int         N      = 4;
  localparam int         HC [N] = '{2, 2, 1, 5};
  localparam logic [3:0] EX [N] = '{4'b1000, 4'b1110, 4'b1000, 4'b0110};
  localparam int         BW [N] = '{8, 8, 4, 20};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] rand_tt = 4'b0000;
  logic       glitch_en = 1'b0;
  logic       cmp_en = 1'b0;

  logic [N-1:0] a, b, busy, done, pass, g, glitch;
  logic [3:0]   fail_vec [N];
  logic [2:0]   fail_count [N];

  int checks = 0;
  int errors = 0;

  // Model: c_m = position in run (0 idle, 1..4H driving, 4H+1 finish)
  int         c_m  [N] = '{default: 0};
  logic [3:0] fv_m [N] = '{default: 4'b0000};
  logic       pass_m [N] = '{default: 1'b0};
  int         blen [N] = '{default: 0};

  always #5 clk = ~clk;

  function automatic logic gate_fn(input logic [2:0] m, input logic [1:0] v, input logic [3:0] tt);
    case (m)
      3'd0:    gate_fn = (v == 2'd3);
      3'd1:    gate_fn = 1'b0;
      3'd2:    gate_fn = 1'b1;
      3'd3:    gate_fn = (v != 2'd0);
      3'd4:    gate_fn = v[1] ^ v[0];
      default: gate_fn = tt[v];
    endcase
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    assign glitch[gi] = glitch_en && (c_m[gi] >= 1) && (c_m[gi] <= 4 * HC[gi]) && ((c_m[gi] % HC[gi]) != 0);
    assign g[gi] = gate_fn(mode, {a[gi], b[gi]}, rand_tt) ^ glitch[gi];
    gate_exerciser #(.HOLD_CYCLES(HC[gi]), .EXPECT(EX[gi])) u_dut (
      .clk(clk), .rst(rst), .start(start), .gate_out(g[gi]),
      .a(a[gi]), .b(b[gi]), .busy(busy[gi]), .done(done[gi]), .pass(pass[gi]),
      .fail_vec(fail_vec[gi]), .fail_count(fail_count[gi])
    );
  end

  task automatic check(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0d expected=%0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model advances just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        c_m[i] = 0; fv_m[i] = 4'b0000; pass_m[i] = 1'b0;
      end else if (c_m[i] == 0) begin
        if (start) begin
          c_m[i] = 1; fv_m[i] = 4'b0000; pass_m[i] = 1'b0;
        end
      end else if (c_m[i] <= 4 * HC[i]) begin
        if (c_m[i] % HC[i] == 0) begin
          int k;
          k = (c_m[i] - 1) / HC[i];
          if (gate_fn(mode, 2'(k), rand_tt) != EX[i][k]) fv_m[i][k] = 1'b1;
        end
        c_m[i]++;
        if (c_m[i] == 4 * HC[i] + 1) pass_m[i] = (fv_m[i] == 4'b0000);
      end else begin
        c_m[i] = 0;
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        logic       run;
        logic [1:0] v;
        run = (c_m[i] >= 1) && (c_m[i] <= 4 * HC[i]);
        v   = run ? 2'((c_m[i] - 1) / HC[i]) : 2'd0;
        check("a", i, int'(a[i]), int'(v[1]));
        check("b", i, int'(b[i]), int'(v[0]));
        check("busy", i, int'(busy[i]), int'(run));
        check("done", i, int'(done[i]), int'(c_m[i] == 4 * HC[i] + 1));
        check("pass", i, int'(pass[i]), int'(pass_m[i]));
        check("fail_vec", i, int'(fail_vec[i]), int'(fv_m[i]));
        check("fail_count", i, int'(fail_count[i]), $countones(fv_m[i]));
        if (busy[i]) begin
          blen[i]++;
        end else begin
          if (done[i]) check("busy_width", i, blen[i], BW[i]);
          blen[i] = 0;
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int j = 0; j < n; j++) @(negedge clk);
  endtask

  // One run from a start pulse; optional extra start pulses while busy
  task automatic start_run(input bit extra, output int t_done, output int n_done);
    start  = 1'b1;
    @(negedge clk);
    t_done = -1;
    n_done = 0;
    for (int n = 1; n <= 26; n++) begin
      if (done[0]) begin
        n_done++;
        if (t_done < 0) t_done = n;
      end
      start = extra && (n < 8) && (n % 3 == 0);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int t_done, n_done, prev, cnt;
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", 0, int'(busy[0]), 0);
    check("rst_fail_vec", 0, int'(fail_vec[0]), 0);

    mode = 3'd0;
    start_run(1'b0, t_done, n_done);
    check("done_time", 0, t_done, 9);
    check("and_pass", 0, int'(pass[0]), 1);
    check("and_vec_e1110", 1, int'(fail_vec[1]), 6);

    mode = 3'd1;
    start_run(1'b0, t_done, n_done);
    check("zero_vec", 0, int'(fail_vec[0]), 8);
    check("zero_cnt", 0, int'(fail_count[0]), 1);
    check("zero_pass", 0, int'(pass[0]), 0);

    mode = 3'd2;
    start_run(1'b0, t_done, n_done);
    check("one_vec", 0, int'(fail_vec[0]), 7);
    check("one_cnt", 0, int'(fail_count[0]), 3);

    mode = 3'd3;
    start_run(1'b1, t_done, n_done);
    check("or_vec", 0, int'(fail_vec[0]), 6);
    check("or_cnt", 0, int'(fail_count[0]), 2);
    check("or_pass", 0, int'(pass[0]), 0);
    check("or_pass_e1110", 1, int'(pass[1]), 1);
    check("restart_ignored_time", 0, t_done, 9);
    check("restart_one_done", 0, n_done, 1);

    // start held high: back-to-back runs
    mode = 3'd4;
    start = 1'b1;
    prev = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done[0]) begin
        if (prev >= 0) check("b2b_period", 0, n - prev, 10);
        prev = n;
      end
    end
    idle_cycles(26);

    // abort with reset during vector 10
    mode = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(a[0] && !b[0]) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_vec10", 0, int'(cnt < 20), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("abort_busy", i, int'(busy[i]), 0);
      check("abort_ab", i, int'({a[i], b[i]}), 0);
      check("abort_cnt", i, int'(fail_count[i]), 0);
    end
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done != '0) cnt++;
    end
    check("abort_no_done", 0, cnt, 0);

    // clean run with glitches away from the sample cycle
    glitch_en = 1'b1;
    start_run(1'b0, t_done, n_done);
    check("glitch_time", 0, t_done, 9);
    check("glitch_pass", 0, int'(pass[0]), 1);
    check("glitch_pass_h1", 2, int'(pass[2]), 1);
    check("glitch_vec_h5", 3, int'(fail_vec[3]), 14);
    check("glitch_cnt_h5", 3, int'(fail_count[3]), 3);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      start     = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      mode      = 3'($urandom_range(0, 5));
      rand_tt   = 4'($urandom_range(0, 15));
      glitch_en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst = 1'b0;
    idle_cycles(26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
